sample_framer: RTL

// - Upstream stage of the fold remover. Collects the serial stream of folded ADC samples into

---
 rtl/sample_framer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sample_framer.sv
// Purpose : frames a serial stream of folded ADC samples into overlapping ROWS+EXTRA_SAMPLES windows.
// Latency : en rises 1 cycle after the edge that accepts a frame's last sample.
// Backpr. : none; every valid sample is accepted, and frames arriving while busy are dropped (overrun).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   in_sample carries a sample this cycle
//   in_sample  signed folded sample, OUT_RES bits
//   ovr_clr    clears the sticky overrun flag (a same-cycle new overrun wins)
//   frame_out  flattened frame, slice k = frame_out[k*OUT_RES +: OUT_RES], k=0 oldest
//   en         one-cycle pulse; frame_out holds the new frame from this cycle on
//   busy       holdoff counter non-zero; a frame completing now would be dropped
//   overrun    sticky: a completed frame was dropped
//   frame_tag  (only with FRAMER_TAG_EN defined) count of issued frames, wraps at 16 bits
//
// Optional feature macro: FRAMER_TAG_EN
module sample_framer #(
  parameter int OUT_RES       = 16,
  parameter int ROWS          = 32,
  parameter int EXTRA_SAMPLES = 4,
  parameter int HOLDOFF       = 33
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  input  logic [OUT_RES-1:0]                        in_sample,
  input  logic                                      ovr_clr,
  output logic [OUT_RES*(ROWS+EXTRA_SAMPLES)-1:0]   frame_out,
  output logic                                      en,
  output logic                                      busy,
  output logic                                      overrun
`ifdef FRAMER_TAG_EN
  ,
  output logic [15:0]                               frame_tag
`endif
);

  localparam int N      = ROWS + EXTRA_SAMPLES;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int WIN_W  = OUT_RES * N;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   fill_cnt;
  logic [CNT_W-1:0]   fill_d;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WIN_W-1:0]   window;
  logic               frame_rdy;
  logic               emit;
  logic               drop;

  assign busy = (hold_cnt != '0);
  assign emit = frame_rdy && !busy;
  assign drop = frame_rdy && busy;

  // Window: newest sample enters the top slice, everything else moves one slice down,
  // so slice 0 is always the oldest sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window <= '0;
    end else if (in_valid) begin
      window <= {in_sample, window[WIN_W-1:OUT_RES]};
    end
  end

  // Frame detection. The first frame needs a full window; after that every ROWS
  // samples complete a frame, which gives the EXTRA_SAMPLES overlap.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_cnt;
    frame_rdy = 1'b0;
    if (state_q == ST_FILL) begin
      if (fill_cnt == CNT_W'(N)) begin
        frame_rdy = 1'b1;
        state_d   = ST_RUN;
      end
    end else begin
      if (fill_cnt == CNT_W'(ROWS)) begin
        frame_rdy = 1'b1;
      end
    end
    // A sample accepted on the frame-boundary edge already belongs to the next
    // frame, so it seeds the restarted count to keep frames on ROWS boundaries.
    if (frame_rdy) begin
      fill_d = in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      fill_d = fill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FILL;
      fill_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= fill_d;
    end
  end

  // Frame hand-off and holdoff. A frame is issued only when the previous sweep
  // has finished; otherwise it is dropped and flagged, frame_out stays put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_out <= '0;
      en        <= 1'b0;
      hold_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      en <= emit;
      if (emit) begin
        frame_out <= window;
        hold_cnt  <= HOLD_W'(HOLDOFF - 1);
      end else if (busy) begin
        hold_cnt  <= hold_cnt - HOLD_W'(1);
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef FRAMER_TAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tag <= '0;
    end else if (emit) begin
      frame_tag <= frame_tag + 16'd1;
    end
  end
`endif

endmodule
